// File: rtl/pixel_serializer_pkg.sv
// Shared camera/pixel definitions: bus widths, serializer FSM encoding and frame size.
package pixel_serializer_pkg;

    localparam int BYTE_W               = 8;
    localparam int PIXEL_W              = 2 * BYTE_W;
    localparam int FRAME_PIXELS_DEFAULT = 76800;
    localparam int CNT_W                = 17;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;

endpackage

// File: rtl/pixel_serializer_if.sv
// Pixel-in / byte-out handshake bundle; slave is the serializer's view, master the environment's.
interface pixel_serializer_if;
    import pixel_serializer_pkg::*;

    logic               abort;
    logic [PIXEL_W-1:0] pixel_in;
    logic               pixel_valid;
    logic               pixel_ready;
    logic [BYTE_W-1:0]  byte_out;
    logic               byte_valid;
    logic               byte_ready;
    logic               byte_last;
    logic               frame_done;
    logic [CNT_W-1:0]   pixel_count;

    modport master (
        output abort, pixel_in, pixel_valid, byte_ready,
        input  pixel_ready, byte_out, byte_valid, byte_last, frame_done, pixel_count
    );

    modport slave (
        input  abort, pixel_in, pixel_valid, byte_ready,
        output pixel_ready, byte_out, byte_valid, byte_last, frame_done, pixel_count
    );

endinterface

// File: rtl/pixel_serializer_frame_pixel_counter.sv
// Mod-MAX counter with enable, synchronous clear and is_last flag (shared with capture-side frame logic).
// Latency: count updates on the edge after en; is_last is combinational from count.
// Backpressure: none; the caller gates en.
module frame_pixel_counter #(
    parameter int unsigned MAX = 76800,
    parameter int unsigned W   = 17
) (
    input  logic         clock,
    input  logic         clear_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         is_last
);

    assign is_last = (count == W'(MAX - 1));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= is_last ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/pixel_serializer.sv
// Splits each 16-bit pixel into two bytes, order set by MSB_FIRST, and flags the last byte of a frame.
// Latency: pixel accepted at edge N shows its first byte from cycle N+1; 1 byte/cycle sustained.
// Backpressure: byte_ready low holds the byte; pixel_ready is combinational from byte_ready in SECOND.
module pixel_serializer #(
    parameter bit MSB_FIRST    = 1'b1,
    parameter int FRAME_PIXELS = pixel_serializer_pkg::FRAME_PIXELS_DEFAULT
) (
    input logic               clock,
    input logic               clear_n,
    pixel_serializer_if.slave bus
);
    import pixel_serializer_pkg::*;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PIXEL_W-1:0] buffer;
    logic [BYTE_W-1:0]  first_byte;
    logic [BYTE_W-1:0]  second_byte;
    logic               frame_done_q;
    logic               is_last;
    logic               xfer;
    logic               accept;
    logic               pixel_done;

    // abort wins over both handshakes in its cycle
    assign bus.pixel_ready = !bus.abort &&
                             ((state == S_IDLE) || (state == S_SECOND && bus.byte_ready));
    assign bus.byte_valid  = (state == S_FIRST) || (state == S_SECOND);
    assign xfer            = bus.byte_valid && bus.byte_ready && !bus.abort;
    assign accept          = bus.pixel_valid && bus.pixel_ready;
    assign pixel_done      = xfer && (state == S_SECOND);

    assign first_byte  = MSB_FIRST ? buffer[PIXEL_W-1:BYTE_W] : buffer[BYTE_W-1:0];
    assign second_byte = MSB_FIRST ? buffer[BYTE_W-1:0] : buffer[PIXEL_W-1:BYTE_W];

    assign bus.byte_out   = (state == S_FIRST)  ? first_byte  :
                            (state == S_SECOND) ? second_byte : '0;
    assign bus.byte_last  = (state == S_SECOND) && is_last;
    assign bus.frame_done = frame_done_q;

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (accept) state_nxt = S_FIRST;
                S_FIRST:  if (xfer)   state_nxt = S_SECOND;
                S_SECOND: if (xfer)   state_nxt = accept ? S_FIRST : S_IDLE;
                default:              state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state        <= S_IDLE;
            buffer       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= pixel_done && is_last;
            if (accept) begin
                buffer <= bus.pixel_in;
            end
        end
    end

    frame_pixel_counter #(
        .MAX (FRAME_PIXELS),
        .W   (CNT_W)
    ) u_counter (
        .clock   (clock),
        .clear_n (clear_n),
        .clr     (bus.abort),
        .en      (pixel_done),
        .count   (bus.pixel_count),
        .is_last (is_last)
    );

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed table-driven bench: dut_a is MSB-first with a full-size frame, dut_b LSB-first with a 3-pixel frame.
module tb_pixel_serializer;
    import pixel_serializer_pkg::*;

    logic clock = 1'b0;
    logic clear_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    pixel_serializer_if ifa();
    pixel_serializer_if ifb();

    pixel_serializer #(.MSB_FIRST(1'b1), .FRAME_PIXELS(76800)) dut_a (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (ifa.slave)
    );

    pixel_serializer #(.MSB_FIRST(1'b0), .FRAME_PIXELS(3)) dut_b (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (ifb.slave)
    );

    typedef struct {
        bit          sel;   // 0 = dut_a, 1 = dut_b
        bit          ab;
        bit          pv;
        logic [15:0] pin;
        bit          br;
        bit          pr;
        bit          bv;
        logic [7:0]  bo;
        bit          bl;
        bit          fd;
        logic [16:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit sel, bit ab, bit pv, logic [15:0] pin, bit br,
                                bit pr, bit bv, logic [7:0] bo, bit bl, bit fd, logic [16:0] cnt);
        vec_t v;
        v.sel = sel; v.ab = ab; v.pv = pv; v.pin = pin; v.br = br;
        v.pr = pr; v.bv = bv; v.bo = bo; v.bl = bl; v.fd = fd; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(string tag, bit sel, bit pr, bit bv, logic [7:0] bo,
                                 bit bl, bit fd, logic [16:0] cnt);
        if (sel == 1'b0) begin
            check({tag, ".pixel_ready"}, 32'(ifa.pixel_ready), 32'(pr));
            check({tag, ".byte_valid"},  32'(ifa.byte_valid),  32'(bv));
            check({tag, ".byte_out"},    32'(ifa.byte_out),    32'(bo));
            check({tag, ".byte_last"},   32'(ifa.byte_last),   32'(bl));
            check({tag, ".frame_done"},  32'(ifa.frame_done),  32'(fd));
            check({tag, ".pixel_count"}, 32'(ifa.pixel_count), 32'(cnt));
        end else begin
            check({tag, ".pixel_ready"}, 32'(ifb.pixel_ready), 32'(pr));
            check({tag, ".byte_valid"},  32'(ifb.byte_valid),  32'(bv));
            check({tag, ".byte_out"},    32'(ifb.byte_out),    32'(bo));
            check({tag, ".byte_last"},   32'(ifb.byte_last),   32'(bl));
            check({tag, ".frame_done"},  32'(ifb.frame_done),  32'(fd));
            check({tag, ".pixel_count"}, 32'(ifb.pixel_count), 32'(cnt));
        end
    endtask

    initial begin
        clear_n         = 1'b0;
        ifa.abort       = 1'b0; ifa.pixel_valid = 1'b0; ifa.pixel_in = '0; ifa.byte_ready = 1'b1;
        ifb.abort       = 1'b0; ifb.pixel_valid = 1'b0; ifb.pixel_in = '0; ifb.byte_ready = 1'b1;

        // sel ab pv pin br | pr bv bo bl fd cnt
        // single pixel, MSB first
        add(0,0,1,16'hF81F,1, 1,0,8'h00,0,0,0);
        add(0,0,0,16'h0000,1, 0,1,8'hF8,0,0,0);
        add(0,0,0,16'h0000,1, 1,1,8'h1F,0,0,0);
        add(0,0,0,16'h0000,1, 1,0,8'h00,0,0,1);
        // back-to-back, no bubbles
        add(0,0,1,16'h0123,1, 1,0,8'h00,0,0,1);
        add(0,0,1,16'h4567,1, 0,1,8'h01,0,0,1);
        add(0,0,1,16'h4567,1, 1,1,8'h23,0,0,1);
        add(0,0,1,16'h89AB,1, 0,1,8'h45,0,0,2);
        add(0,0,1,16'h89AB,1, 1,1,8'h67,0,0,2);
        add(0,0,1,16'hCDEF,1, 0,1,8'h89,0,0,3);
        add(0,0,1,16'hCDEF,1, 1,1,8'hAB,0,0,3);
        add(0,0,0,16'h0000,1, 0,1,8'hCD,0,0,4);
        add(0,0,0,16'h0000,1, 1,1,8'hEF,0,0,4);
        // backpressure: 5 stalled cycles in FIRST while another pixel is offered
        add(0,0,1,16'hABCD,1, 1,0,8'h00,0,0,5);
        for (int i = 0; i < 5; i++) add(0,0,1,16'h1234,0, 0,1,8'hAB,0,0,5);
        add(0,0,0,16'h0000,1, 0,1,8'hAB,0,0,5);
        add(0,0,0,16'h0000,0, 0,1,8'hCD,0,0,5);
        add(0,0,0,16'h0000,1, 1,1,8'hCD,0,0,5);
        add(0,0,0,16'h0000,1, 1,0,8'h00,0,0,6);
        // abort in SECOND with a pixel offered
        add(0,0,1,16'h5A5A,1, 1,0,8'h00,0,0,6);
        add(0,0,1,16'h0F0F,1, 0,1,8'h5A,0,0,6);
        add(0,1,1,16'h0F0F,1, 0,1,8'h5A,0,0,6);
        add(0,0,0,16'h0000,1, 1,0,8'h00,0,0,0);
        add(0,0,1,16'hBEEF,1, 1,0,8'h00,0,0,0);
        add(0,0,0,16'h0000,1, 0,1,8'hBE,0,0,0);
        add(0,0,0,16'h0000,1, 1,1,8'hEF,0,0,0);
        add(0,0,0,16'h0000,1, 1,0,8'h00,0,0,1);
        // frame wrap on dut_b: 3-pixel frame, LSB first
        add(1,0,1,16'h1122,1, 1,0,8'h00,0,0,0);
        add(1,0,1,16'h3344,1, 0,1,8'h22,0,0,0);
        add(1,0,1,16'h3344,1, 1,1,8'h11,0,0,0);
        add(1,0,1,16'h5566,1, 0,1,8'h44,0,0,1);
        add(1,0,1,16'h5566,1, 1,1,8'h33,0,0,1);
        add(1,0,0,16'h0000,1, 0,1,8'h66,0,0,2);
        add(1,0,0,16'h0000,1, 1,1,8'h55,1,0,2);
        add(1,0,0,16'h0000,1, 1,0,8'h00,0,1,0);
        add(1,0,0,16'h0000,1, 1,0,8'h00,0,0,0);

        #12;
        check_outputs("reset_a", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 17'd0);
        check_outputs("reset_b", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 17'd0);
        #5 clear_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clock); #1;
            ifa.pixel_valid = 1'b0; ifa.abort = 1'b0; ifa.byte_ready = 1'b1; ifa.pixel_in = '0;
            ifb.pixel_valid = 1'b0; ifb.abort = 1'b0; ifb.byte_ready = 1'b1; ifb.pixel_in = '0;
            if (vecs[i].sel == 1'b0) begin
                ifa.abort = vecs[i].ab; ifa.pixel_valid = vecs[i].pv;
                ifa.pixel_in = vecs[i].pin; ifa.byte_ready = vecs[i].br;
            end else begin
                ifb.abort = vecs[i].ab; ifb.pixel_valid = vecs[i].pv;
                ifb.pixel_in = vecs[i].pin; ifb.byte_ready = vecs[i].br;
            end
            @(negedge clock);
            check_outputs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].pr, vecs[i].bv,
                          vecs[i].bo, vecs[i].bl, vecs[i].fd, vecs[i].cnt);
        end

        // asynchronous reset while dut_a sits stalled in FIRST
        @(posedge clock); #1;
        ifa.pixel_valid = 1'b1; ifa.pixel_in = 16'h7E81; ifa.byte_ready = 1'b0;
        @(posedge clock); #1;
        ifa.pixel_valid = 1'b0;
        @(negedge clock);
        check_outputs("pre_reset", 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 17'd1);
        #2 clear_n = 1'b0;
        #1;
        check("async_rst.byte_valid",  32'(ifa.byte_valid),  32'd0);
        check("async_rst.byte_out",    32'(ifa.byte_out),    32'd0);
        check("async_rst.byte_last",   32'(ifa.byte_last),   32'd0);
        check("async_rst.frame_done",  32'(ifa.frame_done),  32'd0);
        check("async_rst.pixel_count", 32'(ifa.pixel_count), 32'd0);
        @(posedge clock); #1;
        clear_n = 1'b1; ifa.byte_ready = 1'b1;
        @(negedge clock);
        check_outputs("post_reset", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 17'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
